bludge_penalty_timer: RTL

//   Consumes the four *_bludged flags from bludger_controller and applies the hit penalty.
//   On a hit, the player is frozen for STUN_TICKS movement ticks.

---
 rtl/bludge_penalty_timer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bludge_penalty_timer.sv
// Hit penalty sequencer for the four bludger targets: stun, then immunity with flag clearing,
// plus saturating per-team hit tallies for the scoreboard.
module bludge_penalty_timer #(
  parameter int TICK_DIV     = 250000,
  parameter int STUN_TICKS   = 150,
  parameter int IMMUNE_TICKS = 50,
  parameter int HIT_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_initiated,
  input  logic                 blue_ver_bludged,
  input  logic                 blue_hor_bludged,
  input  logic                 red_ver_bludged,
  input  logic                 red_hor_bludged,
  output logic                 blue_ver_clean,
  output logic                 blue_hor_clean,
  output logic                 red_ver_clean,
  output logic                 red_hor_clean,
  output logic                 blue_ver_frozen,
  output logic                 blue_hor_frozen,
  output logic                 red_ver_frozen,
  output logic                 red_hor_frozen,
  output logic [HIT_WIDTH-1:0] blue_hits,
  output logic [HIT_WIDTH-1:0] red_hits
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (STUN_TICKS > IMMUNE_TICKS) ? STUN_TICKS : IMMUNE_TICKS;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [HIT_WIDTH-1:0] HIT_MAX = '1;

  typedef enum logic [1:0] {IDLE, STUN, IMMUNE} state_t;

  logic          game_active;
  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    bludged;
  logic [3:0]    entering;
  logic [3:0]    frozen;
  logic [3:0]    clean;

  assign bludged = {red_hor_bludged, red_ver_bludged, blue_hor_bludged, blue_ver_bludged};
  assign tick    = game_active && (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_active <= 1'b0;
      presc       <= '0;
    end else begin
      if (game_initiated)
        game_active <= 1'b1;
      if (game_active)
        presc <= tick ? '0 : presc + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      state_t        state, state_next;
      logic [TW-1:0] timer, timer_next;
      logic          frozen_q, clean_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state    <= IDLE;
          timer    <= '0;
          frozen_q <= 1'b0;
          clean_q  <= 1'b0;
        end else begin
          state    <= state_next;
          timer    <= timer_next;
          frozen_q <= (state == STUN);
          clean_q  <= (state == IMMUNE) || !game_active;
        end
      end

      always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
          IDLE: begin
            if (game_active && bludged[gi]) begin
              state_next = STUN;
              timer_next = TW'(STUN_TICKS - 1);
            end
          end
          STUN: begin
            if (tick) begin
              if (timer == '0) begin
                state_next = IMMUNE;
                timer_next = TW'(IMMUNE_TICKS - 1);
              end else begin
                timer_next = timer - 1'b1;
              end
            end
          end
          IMMUNE: begin
            if (tick) begin
              if (timer == '0)
                state_next = IDLE;
              else
                timer_next = timer - 1'b1;
            end
          end
          default: begin
            state_next = IDLE;
            timer_next = '0;
          end
        endcase
      end

      assign entering[gi] = (state == IDLE) && (state_next == STUN);
      assign frozen[gi]   = frozen_q;
      assign clean[gi]    = clean_q;
    end
  endgenerate

  // Both players of a team can be hit on the same edge, so the increment is 0..2.
  function automatic logic [HIT_WIDTH-1:0] sat_add(input logic [HIT_WIDTH-1:0] a,
                                                    input logic [1:0] inc);
    logic [HIT_WIDTH+1:0] sum;
    sum = {2'b00, a} + {{HIT_WIDTH{1'b0}}, inc};
    return (sum > {2'b00, HIT_MAX}) ? HIT_MAX : sum[HIT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blue_hits <= '0;
      red_hits  <= '0;
    end else begin
      blue_hits <= sat_add(blue_hits, {1'b0, entering[0]} + {1'b0, entering[1]});
      red_hits  <= sat_add(red_hits,  {1'b0, entering[2]} + {1'b0, entering[3]});
    end
  end

  assign blue_ver_frozen = frozen[0];
  assign blue_hor_frozen = frozen[1];
  assign red_ver_frozen  = frozen[2];
  assign red_hor_frozen  = frozen[3];
  assign blue_ver_clean  = clean[0];
  assign blue_hor_clean  = clean[1];
  assign red_ver_clean   = clean[2];
  assign red_hor_clean   = clean[3];

endmodule
